// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MEM-stage data cache.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    DONE
  } dcache_state_t;

  localparam int DEFAULT_INDEX_BITS = 10;

  // Byte-lane enables: one-hot lane for byte accesses, all lanes for words.
  function automatic logic [3:0] be_from_offset(input logic [1:0] offset, input logic is_byte);
    return is_byte ? (4'b0001 << offset) : 4'b1111;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for a direct-mapped, one-word-per-line cache.
// Combinational read port, one synchronous write port with byte enables.
module dcache_array #(
  parameter int INDEX_BITS = 10,
  parameter int TAG_BITS   = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [31:0]           rd_line_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [3:0]            wr_be_i,
  input  logic [31:0]           wr_line_i,
  input  logic                  wr_set_valid_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_mem [LINES];

  // Only valid bits are cleared by reset; tags and data keep stale contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i && wr_set_valid_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && wr_set_valid_i) begin
      tag_mem[wr_index_i] <= wr_tag_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_mem[rd_index_i];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [LINES];

      always_ff @(posedge clk) begin
        if (wr_en_i && wr_be_i[gi]) begin
          lane_mem[wr_index_i] <= wr_line_i[8*gi +: 8];
        end
      end

      assign rd_line_o[8*gi +: 8] = lane_mem[rd_index_i];
    end
  endgenerate

endmodule

// File: rtl/mem_stage_dcache.sv
// MEM-stage data cache controller: direct-mapped, write-through, no write-allocate,
// stalling the pipeline on read misses and on every store.
module mem_stage_dcache
  import mips_mem_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        is_LB_SB,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [7:0]  cache_data_out [0:3],
  output logic [1:0]  mem_block,
  output logic        freeze,
  output logic        mm_req,
  output logic        mm_we,
  output logic [31:0] mm_addr,
  output logic [31:0] mm_wdata,
  output logic [3:0]  mm_be,
  input  logic        mm_ready,
  input  logic [31:0] mm_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  dcache_state_t state_q;
  logic [31:2]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          wr_hit_q;
  logic [31:0]   hit_count_q;
  logic [31:0]   miss_count_q;

  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_line;
  logic                  hit;
  logic                  start_wr;
  logic                  start_rd;
  logic [3:0]            req_be;
  logic [31:0]           req_wdata;
  logic                  arr_wr_en;
  logic                  fill;

  assign hit = rd_valid && (rd_tag == address[31:INDEX_BITS+2]);

  assign start_wr  = (state_q == IDLE) && mem_write;
  assign start_rd  = (state_q == IDLE) && !mem_write && mem_read && !hit;
  assign req_be    = mem_write ? be_from_offset(address[1:0], is_LB_SB) : 4'b1111;
  assign req_wdata = !mem_write ? 32'h0 :
                     (is_LB_SB ? {4{write_data[7:0]}} : write_data);

  // New requests are driven straight from the inputs so the stall starts in the
  // same cycle; once waiting, the captured copy keeps the bus stable.
  always_comb begin
    mm_req   = 1'b0;
    mm_we    = 1'b0;
    mm_addr  = 32'h0;
    mm_wdata = 32'h0;
    mm_be    = 4'h0;
    freeze   = 1'b0;
    if (!rst) begin
      if (start_wr || start_rd) begin
        mm_req   = 1'b1;
        mm_we    = start_wr;
        mm_addr  = {address[31:2], 2'b00};
        mm_wdata = req_wdata;
        mm_be    = req_be;
        freeze   = 1'b1;
      end else if (state_q == RD_WAIT || state_q == WR_WAIT) begin
        mm_req   = 1'b1;
        mm_we    = (state_q == WR_WAIT);
        mm_addr  = {addr_q, 2'b00};
        mm_wdata = wdata_q;
        mm_be    = be_q;
        freeze   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      wr_hit_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_wr || start_rd) begin
            addr_q   <= address[31:2];
            wdata_q  <= req_wdata;
            be_q     <= req_be;
            wr_hit_q <= hit;
          end
          if (start_wr) begin
            state_q <= WR_WAIT;
          end else if (start_rd) begin
            state_q      <= RD_WAIT;
            miss_count_q <= miss_count_q + 32'd1;
          end else if (mem_read) begin
            hit_count_q <= hit_count_q + 32'd1;
          end
        end
        RD_WAIT: if (mm_ready) state_q <= DONE;
        WR_WAIT: if (mm_ready) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array updates only on completion of an outstanding transaction.
  assign fill      = (state_q == RD_WAIT) && mm_ready;
  assign arr_wr_en = fill || ((state_q == WR_WAIT) && mm_ready && wr_hit_q);

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk            (clk),
    .rst            (rst),
    .rd_index_i     (address[INDEX_BITS+1:2]),
    .rd_valid_o     (rd_valid),
    .rd_tag_o       (rd_tag),
    .rd_line_o      (rd_line),
    .wr_en_i        (arr_wr_en),
    .wr_index_i     (addr_q[INDEX_BITS+1:2]),
    .wr_be_i        (fill ? 4'b1111 : be_q),
    .wr_line_i      (fill ? mm_rdata : wdata_q),
    .wr_set_valid_i (fill),
    .wr_tag_i       (addr_q[31:INDEX_BITS+2])
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_out
      assign cache_data_out[gi] = (mem_read && hit) ? rd_line[8*gi +: 8] : 8'h00;
    end
  endgenerate

  assign mem_block  = address[1:0];
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Bench for mem_stage_dcache: directed scenarios plus random traffic against a
// behavioural cache/memory model.
module tb_mem_stage_dcache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        is_LB_SB = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [7:0]  cache_data_out [0:3];
  logic [1:0]  mem_block;
  logic        freeze;
  logic        mm_req;
  logic        mm_we;
  logic [31:0] mm_addr;
  logic [31:0] mm_wdata;
  logic [3:0]  mm_be;
  logic        mm_ready = 1'b0;
  logic [31:0] mm_rdata = 32'h0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  mem_stage_dcache dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .is_LB_SB       (is_LB_SB),
    .address        (address),
    .write_data     (write_data),
    .cache_data_out (cache_data_out),
    .mem_block      (mem_block),
    .freeze         (freeze),
    .mm_req         (mm_req),
    .mm_we          (mm_we),
    .mm_addr        (mm_addr),
    .mm_wdata       (mm_wdata),
    .mm_be          (mm_be),
    .mm_ready       (mm_ready),
    .mm_rdata       (mm_rdata),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  wire [31:0] cdo_word = {cache_data_out[3], cache_data_out[2], cache_data_out[1], cache_data_out[0]};

  // Reference model: cache lines, main memory and expected counters.
  bit          ref_valid [1024];
  logic [19:0] ref_tag   [1024];
  logic [31:0] ref_data  [1024];
  logic [31:0] main_mem  [bit [29:0]];
  int          exp_hits;
  int          exp_misses;
  int          n_checks;
  int          n_fails;
  int          n_txn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input bit [29:0] w);
    if (!main_mem.exists(w)) main_mem[w] = $urandom;
    return main_mem[w];
  endfunction

  function automatic void ref_reset();
    for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input bit byt, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    if (byt) r[8*off +: 8] = wd[7:0];
    else r = wd;
    return r;
  endfunction

  // One MEM-stage instruction: present it, play memory with latency lat, check
  // every stall cycle and the release cycle.
  task automatic do_access(input bit rd, input bit wr, input bit byt, input logic [31:0] a,
                           input logic [31:0] wd, input int lat);
    bit [29:0]   waddr;
    int          idx;
    logic [19:0] tg;
    bit          is_hit;
    bit          stall;
    int          fcnt;
    logic [31:0] rword;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    waddr = a[31:2];
    idx   = int'(a[11:2]);
    tg    = a[31:12];
    @(negedge clk);
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
    mem_read = rd; mem_write = wr; is_LB_SB = byt; address = a; write_data = wd;
    #1;
    is_hit = ref_valid[idx] && ref_tag[idx] == tg;
    stall  = wr || (rd && !is_hit);
    n_txn++;
    $display("txn %0d: rd=%0b wr=%0b byte=%0b addr=%h wdata=%h lat=%0d hit=%0b",
             n_txn, rd, wr, byt, a, wd, lat, is_hit);
    check("mem_block", {30'h0, mem_block}, {30'h0, a[1:0]});
    check("cdo_idle", cdo_word, (rd && is_hit) ? ref_data[idx] : 32'h0);
    if (!stall) begin
      check("freeze_nostall", {31'h0, freeze}, 32'h0);
      check("mm_req_nostall", {31'h0, mm_req}, 32'h0);
      if (rd) exp_hits++;
      return;
    end
    if (!wr) exp_misses++;
    exp_be    = wr ? (byt ? (4'b0001 << a[1:0]) : 4'b1111) : 4'b1111;
    exp_wdata = byt ? {4{wd[7:0]}} : wd;
    rword     = 32'h0;
    fcnt      = 0;
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      check("freeze_wait", {31'h0, freeze}, 32'h1);
      check("mm_req_wait", {31'h0, mm_req}, 32'h1);
      check("mm_we", {31'h0, mm_we}, {31'h0, wr});
      check("mm_addr", mm_addr, {a[31:2], 2'b00});
      check("mm_be", {28'h0, mm_be}, {28'h0, exp_be});
      if (wr) check("mm_wdata", mm_wdata, exp_wdata);
      if (freeze) fcnt++;
      if (c == lat) begin
        rword    = wr ? $urandom : mem_word(waddr);
        mm_ready = 1'b1;
        mm_rdata = rword;
      end
    end
    if (wr) begin
      main_mem[waddr] = merge(mem_word(waddr), wd, byt, a[1:0]);
      if (is_hit) ref_data[idx] = merge(ref_data[idx], wd, byt, a[1:0]);
    end else begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
      ref_data[idx]  = rword;
    end
    @(negedge clk);
    mm_ready = 1'b0;
    mm_rdata = $urandom;
    #1;
    check("freeze_done", {31'h0, freeze}, 32'h0);
    check("mm_req_done", {31'h0, mm_req}, 32'h0);
    check("stall_len", fcnt, lat + 1);
    if (rd) begin
      is_hit = ref_valid[idx] && ref_tag[idx] == tg;
      check("cdo_done", cdo_word, is_hit ? ref_data[idx] : 32'h0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    n_txn    = 0;
    ref_reset();
    main_mem[30'h10] = 32'hDEADBEEF;
    main_mem[30'h410] = 32'h0BADF00D;
    #2;
    check("rst_freeze", {31'h0, freeze}, 32'h0);
    check("rst_mm_req", {31'h0, mm_req}, 32'h0);
    check("rst_hits", hit_count, 32'h0);
    check("rst_misses", miss_count, 32'h0);
    check("rst_cdo", cdo_word, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss, then hit
    do_access(1, 0, 0, 32'h0000_0040, 32'h0, 3);
    check("cold_fill", ref_data[16], 32'hDEADBEEF);
    do_access(1, 0, 0, 32'h0000_0040, 32'h0, 3);
    // Conflict misses on index 0x10
    do_access(1, 0, 0, 32'h0000_1040, 32'h0, 2);
    do_access(1, 0, 0, 32'h0000_0040, 32'h0, 1);
    // SB hit on byte 3, then read back
    do_access(0, 1, 1, 32'h0000_0043, 32'h0000_00AA, 2);
    do_access(1, 0, 0, 32'h0000_0040, 32'h0, 2);
    check("sb_line", cdo_word, 32'hAAADBEEF);
    check("miss_after_conflict", miss_count, 32'd3);
    // SW miss does not allocate
    do_access(0, 1, 0, 32'h0000_0080, 32'h1234_5678, 3);
    do_access(1, 0, 0, 32'h0000_0080, 32'h0, 2);
    // Read+write together is a write
    do_access(1, 1, 0, 32'h0000_0040, 32'hCAFE_0001, 2);
    do_access(0, 0, 0, 32'h0, 32'h0, 1);

    // Reset in the middle of a read miss, then a stray mm_ready
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; is_LB_SB = 1'b0; address = 32'h0000_0200;
    #1;
    check("pre_rst_freeze", {31'h0, freeze}, 32'h1);
    @(negedge clk);
    #1;
    check("rdwait_freeze", {31'h0, freeze}, 32'h1);
    rst = 1'b1;
    #1;
    ref_reset();
    $display("txn reset mid-miss addr=%h", address);
    check("midrst_mm_req", {31'h0, mm_req}, 32'h0);
    check("midrst_freeze", {31'h0, freeze}, 32'h0);
    check("midrst_hits", hit_count, 32'h0);
    check("midrst_misses", miss_count, 32'h0);
    check("midrst_mm_addr", mm_addr, 32'h0);
    check("midrst_mm_be", {28'h0, mm_be}, 32'h0);
    check("midrst_cdo", cdo_word, 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    mm_ready = 1'b1; mm_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mm_ready = 1'b0;
    do_access(1, 0, 0, 32'h0000_0200, 32'h0, 2);

    // Random traffic over a few indices and tags to force hits and conflicts
    for (int i = 0; i < 300; i++) begin
      int          op;
      logic [31:0] a;
      logic [31:0] ix;
      op = $urandom_range(0, 9);
      ix = (($urandom_range(0, 2) == 0) ? 32'h3FF : 32'h10 + 32'($urandom_range(0, 2)));
      a  = (32'($urandom_range(0, 2)) << 12) | (ix << 2) | 32'($urandom_range(0, 3));
      if (op < 5)      do_access(1, 0, $urandom_range(0, 1) == 1, a, 32'h0, $urandom_range(1, 4));
      else if (op < 8) do_access(0, 1, $urandom_range(0, 1) == 1, a, $urandom, $urandom_range(1, 4));
      else if (op < 9) do_access(1, 1, $urandom_range(0, 1) == 1, a, $urandom, $urandom_range(1, 4));
      else             do_access(0, 0, 0, a, 32'h0, 1);
    end

    @(negedge clk);
    check("final_hits", hit_count, exp_hits);
    check("final_misses", miss_count, exp_misses);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
